// File: rtl/instr_fetch_decode_frontend.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode_frontend
//
// Front end of the IITB-RISC 16-bit pipeline. It has three parts:
//   - fetch: the PC and an internal instruction memory with a write port
//   - IF/ID: a pipeline register that holds {instruction, pc}
//   - decode: combinational classification of the instruction held in IF/ID
//
// Ports:
//   clk        in   1         rising-edge clock for all state
//   resetn     in   1         asynchronous active-low reset
//   stall      in   1         hold PC and IF/ID when high
//   imem_we    in   1         instruction memory write enable
//   imem_waddr in   IMEM_AW   instruction memory write address
//   imem_wdata in   16        instruction memory write data
//   pc_id      out  WIDTH     PC of the instruction in ID
//   instr_id   out  WIDTH     instruction in the IF/ID register
//   R_I_J      out  2         class: 00 R, 01 I, 10 J, 11 invalid/bubble
//   alu_op     out  5         decoded operation code
//   I_12       out  12        operand field instr_id[11:0]
// -----------------------------------------------------------------------------

// Generic K-bit register with load enable and asynchronous active-low reset
// to a parameterised value.
//
// Ports:
//   clk    in   1   clock
//   resetn in   1   asynchronous active-low reset, loads RESET_VAL
//   ld     in   1   load enable
//   d      in   K   data in
//   q      out  K   registered value
module ld_reg #(
    parameter int          K         = 16,
    parameter logic [K-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ld,
    input  logic [K-1:0] d,
    output logic [K-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= RESET_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

module instr_fetch_decode_frontend #(
    parameter int WIDTH      = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [15:0]        imem_wdata,
    output logic [WIDTH-1:0]   pc_id,
    output logic [WIDTH-1:0]   instr_id,
    output logic [1:0]         R_I_J,
    output logic [4:0]         alu_op,
    output logic [11:0]        I_12
);

    // Opcode 1110 is not a legal instruction, so this word travels through
    // the pipeline as a harmless bubble.
    localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(16'hE000);

    logic [15:0]      imem [IMEM_DEPTH];
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr_if;
    logic [3:0]       op;

    // The memory has no reset so it can be preloaded while the core is
    // still held in reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Any PC bit above the memory address range means the fetch is out of
    // range, and a bubble is injected in place of the instruction.
    always_comb begin
        if (pc[WIDTH-1:IMEM_AW] != '0) begin
            instr_if = BUBBLE;
        end else begin
            instr_if = WIDTH'(imem[pc[IMEM_AW-1:0]]);
        end
    end

    // The PC is word addressed and wraps naturally at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= '0;
        end else if (!stall) begin
            pc <= pc + WIDTH'(1);
        end
    end

    ld_reg #(
        .K         (2 * WIDTH),
        .RESET_VAL ({BUBBLE, {WIDTH{1'b0}}})
    ) u_if_id (
        .clk    (clk),
        .resetn (resetn),
        .ld     (~stall),
        .d      ({instr_if, pc}),
        .q      ({instr_id, pc_id})
    );

    assign op = instr_id[15:12];

    // R-type alu_op packs {1, nand, complement, cz}. NAND with CZ = 11 has no
    // meaning and is treated as invalid, while ADD accepts every CZ value.
    always_comb begin
        R_I_J  = 2'b11;
        alu_op = 5'b11111;
        I_12   = 12'h000;
        if (resetn) begin
            case (op)
                4'b0001: begin
                    R_I_J  = 2'b00;
                    alu_op = {1'b1, op[1], instr_id[2], instr_id[1:0]};
                    I_12   = instr_id[11:0];
                end
                4'b0010: begin
                    if (instr_id[1:0] != 2'b11) begin
                        R_I_J  = 2'b00;
                        alu_op = {1'b1, op[1], instr_id[2], instr_id[1:0]};
                        I_12   = instr_id[11:0];
                    end
                end
                4'b0000, 4'b0100, 4'b0101, 4'b1000,
                4'b1001, 4'b1010, 4'b1101: begin
                    R_I_J  = 2'b01;
                    alu_op = {1'b0, op};
                    I_12   = instr_id[11:0];
                end
                4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1111: begin
                    R_I_J  = 2'b10;
                    alu_op = {1'b0, op};
                    I_12   = instr_id[11:0];
                end
                default: begin
                    R_I_J  = 2'b11;
                    alu_op = 5'b11111;
                    I_12   = 12'h000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode_frontend.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decode_frontend
//
// Directed bench for instr_fetch_decode_frontend. The memory is preloaded
// during reset, then the pipeline is run through decode of R/I/J/invalid
// words, a stall with a write to the address being fetched, an asynchronous
// mid-run reset and the out-of-range fetch boundary.
// -----------------------------------------------------------------------------
module tb_instr_fetch_decode_frontend;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [15:0] pc_id;
    logic [15:0] instr_id;
    logic [1:0]  R_I_J;
    logic [4:0]  alu_op;
    logic [11:0] I_12;

    int checks_done;
    int checks_failed;

    instr_fetch_decode_frontend #(
        .WIDTH      (16),
        .IMEM_DEPTH (256),
        .IMEM_AW    (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .stall      (stall),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .pc_id      (pc_id),
        .instr_id   (instr_id),
        .R_I_J      (R_I_J),
        .alu_op     (alu_op),
        .I_12       (I_12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives reset/stall at a falling edge and steps the given number of
    // rising edges, returning at a falling edge so outputs are stable.
    task automatic applyStimulus(input logic rst_val, input logic stall_val,
                                 input int edges);
        resetn = rst_val;
        stall  = stall_val;
        repeat (edges) @(negedge clk);
    endtask

    // Checks the full decoded view of the instruction sitting in ID.
    task automatic checkId(input string tag, input logic [15:0] exp_pc,
                           input logic [15:0] exp_instr, input logic [1:0] exp_class,
                           input logic [4:0] exp_op, input logic [11:0] exp_i12);
        checkOutput({tag, ".pc_id"},    32'(pc_id),    32'(exp_pc));
        checkOutput({tag, ".instr_id"}, 32'(instr_id), 32'(exp_instr));
        checkOutput({tag, ".R_I_J"},    32'(R_I_J),    32'(exp_class));
        checkOutput({tag, ".alu_op"},   32'(alu_op),   32'(exp_op));
        checkOutput({tag, ".I_12"},     32'(I_12),     32'(exp_i12));
    endtask

    logic [15:0] program_words [8];

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        resetn        = 1'b0;
        stall         = 1'b0;
        imem_we       = 1'b0;
        imem_waddr    = '0;
        imem_wdata    = '0;

        program_words[0] = 16'h1051;  // ADZ
        program_words[1] = 16'h2056;  // NCC
        program_words[2] = 16'h2053;  // NAND CZ=11, invalid
        program_words[3] = 16'h0A3F;  // ADI
        program_words[4] = 16'hC123;  // JAL
        program_words[5] = 16'h1234;  // overwritten during the stall
        program_words[6] = 16'hB000;  // invalid opcode
        program_words[7] = 16'h3ABC;  // LHI

        // Preload the whole memory while reset is held; words above the
        // program are ADI with the address as the operand.
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 8'(i);
            imem_wdata = (i < 8) ? program_words[i] : 16'(i);
            @(negedge clk);
            if (i == 1) begin
                checkId("reset", 16'h0000, 16'hE000, 2'b11, 5'b11111, 12'h000);
            end
        end
        imem_we = 1'b0;

        // Fetch starts at address 0 one edge after release.
        applyStimulus(1'b1, 1'b0, 1);
        checkId("adz", 16'h0000, 16'h1051, 2'b00, 5'b10001, 12'h051);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("ncc", 16'h0001, 16'h2056, 2'b00, 5'b11110, 12'h056);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("nand_cz11", 16'h0002, 16'h2053, 2'b11, 5'b11111, 12'h000);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("adi", 16'h0003, 16'h0A3F, 2'b01, 5'b00000, 12'hA3F);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("jal", 16'h0004, 16'hC123, 2'b10, 5'b01100, 12'h123);

        // Stall three edges; the first stalled edge also rewrites the word
        // the held PC is pointing at.
        stall      = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = 8'd5;
        imem_wdata = 16'h5ABC;
        @(negedge clk);
        imem_we = 1'b0;
        checkOutput("stall1.pc_id",    32'(pc_id),    32'h0004);
        checkOutput("stall1.instr_id", 32'(instr_id), 32'hC123);
        for (int s = 2; s <= 3; s++) begin
            applyStimulus(1'b1, 1'b1, 1);
            checkOutput($sformatf("stall%0d.pc_id", s),    32'(pc_id),    32'h0004);
            checkOutput($sformatf("stall%0d.instr_id", s), 32'(instr_id), 32'hC123);
        end
        applyStimulus(1'b1, 1'b0, 1);
        checkId("sw_collision", 16'h0005, 16'h5ABC, 2'b01, 5'b00101, 12'hABC);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("op1011", 16'h0006, 16'hB000, 2'b11, 5'b11111, 12'h000);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("lhi", 16'h0007, 16'h3ABC, 2'b10, 5'b00011, 12'hABC);

        // Reset pulled between edges must clear everything at once.
        #2 resetn = 1'b0;
        #1;
        checkId("async_reset", 16'h0000, 16'hE000, 2'b11, 5'b11111, 12'h000);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("restart", 16'h0000, 16'h1051, 2'b00, 5'b10001, 12'h051);

        // Run to the last in-range word and then past the end of memory.
        applyStimulus(1'b1, 1'b0, 255);
        checkId("last_word", 16'h00FF, 16'h00FF, 2'b01, 5'b00000, 12'h0FF);
        applyStimulus(1'b1, 1'b0, 1);
        checkId("out_of_range", 16'h0100, 16'hE000, 2'b11, 5'b11111, 12'h000);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("past_end.pc_id",    32'(pc_id),    32'h0101);
        checkOutput("past_end.instr_id", 32'(instr_id), 32'hE000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_done, checks_failed);
        $finish;
    end

endmodule
